// File: rtl/coin_tally.sv
// -----------------------------------------------------------------------------
// coin_tally
//   Conditions the four raw coin beam-break inputs and turns each coin passage
//   into exactly one counted event. It keeps a saturating cent total, saturating
//   per-denomination counts and a last-coin latch that the CPU acknowledges.
//
// Ports
//   clock        in   system clock
//   reset        in   synchronous, active-high reset
//   beam_n       in   raw beams, low = broken; [0]=1c [1]=5c [2]=10c [3]=25c
//   clear_total  in   pulse: zero total, counts and saturated
//   coin_ack     in   pulse: CPU consumed last_coin
//   total_cents  out  accumulated cents (saturating)
//   count1/5/10/25 out per-denomination counts (saturating)
//   coin_valid   out  last_coin holds an unacknowledged event
//   last_coin    out  one-hot denomination(s) of the most recent event
//   overrun      out  sticky: event arrived while an event was still pending
//   saturated    out  sticky: total or a count was clamped
//   beam_state   out  debounced broken level per channel, 1 = broken
// -----------------------------------------------------------------------------
module coin_tally #(
    parameter int DEBOUNCE_CYCLES = 30000,
    parameter int TOTAL_W         = 16,
    parameter int COUNT_W         = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         beam_n,
    input  logic               clear_total,
    input  logic               coin_ack,
    output logic [TOTAL_W-1:0] total_cents,
    output logic [COUNT_W-1:0] count1,
    output logic [COUNT_W-1:0] count5,
    output logic [COUNT_W-1:0] count10,
    output logic [COUNT_W-1:0] count25,
    output logic               coin_valid,
    output logic [3:0]         last_coin,
    output logic               overrun,
    output logic               saturated,
    output logic [3:0]         beam_state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TOTAL_W:0]   TOT_ZERO  = {(TOTAL_W+1){1'b0}};
    localparam logic [TOTAL_W:0]   TOTAL_MAX = {1'b0, {TOTAL_W{1'b1}}};
    localparam logic [TOTAL_W:0]   DEN1      = (TOTAL_W+1)'(1);
    localparam logic [TOTAL_W:0]   DEN5      = (TOTAL_W+1)'(5);
    localparam logic [TOTAL_W:0]   DEN10     = (TOTAL_W+1)'(10);
    localparam logic [TOTAL_W:0]   DEN25     = (TOTAL_W+1)'(25);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_BROKEN = 2'd2,
        ST_REL    = 2'd3
    } deb_state_t;

    logic [3:0]         sync1_r;
    logic [3:0]         sync2_r;
    deb_state_t         state_r [4];
    logic [CNT_W-1:0]   cnt_r [4];
    logic [3:0]         beam_state_r;
    logic [3:0]         hit_s;

    logic [TOTAL_W-1:0] total_r;
    logic [COUNT_W-1:0] count_r [4];
    logic               valid_r;
    logic [3:0]         last_r;
    logic               overrun_r;
    logic               sat_r;

    logic [TOTAL_W:0]   add_s;
    logic [TOTAL_W:0]   sum_s;
    logic [TOTAL_W-1:0] total_next_s;
    logic               tot_clamp_s;
    logic [COUNT_W:0]   csum_s [4];
    logic [COUNT_W-1:0] count_next_s [4];
    logic [3:0]         cnt_clamp_s;
    logic               sat_next_s;

    // Two-flop synchroniser; reset presets it to "beam intact".
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 4'b1111;
            sync2_r <= 4'b1111;
        end else begin
            sync1_r <= beam_n;
            sync2_r <= sync1_r;
        end
    end

    // A hit is the last ARM cycle with the beam still broken: the same
    // condition that moves the channel FSM to BROKEN on this edge.
    always_comb begin
        hit_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if ((state_r[i] == ST_ARM) && !sync2_r[i] && (cnt_r[i] == CNT_LAST)) begin
                hit_s[i] = 1'b1;
            end else begin
                hit_s[i] = 1'b0;
            end
        end
    end

    // Per-channel debounce FSMs with registered debounced level.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                state_r[i] <= ST_IDLE;
                cnt_r[i]   <= {CNT_W{1'b0}};
            end
            beam_state_r <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case (state_r[i])
                    ST_IDLE: begin
                        if (!sync2_r[i]) begin
                            cnt_r[i]   <= {CNT_W{1'b0}};
                            state_r[i] <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        if (sync2_r[i]) begin
                            state_r[i] <= ST_IDLE;
                        end else if (cnt_r[i] == CNT_LAST) begin
                            state_r[i]      <= ST_BROKEN;
                            beam_state_r[i] <= 1'b1;
                        end else begin
                            cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                        end
                    end
                    ST_BROKEN: begin
                        if (sync2_r[i]) begin
                            cnt_r[i]   <= {CNT_W{1'b0}};
                            state_r[i] <= ST_REL;
                        end
                    end
                    ST_REL: begin
                        if (!sync2_r[i]) begin
                            state_r[i] <= ST_BROKEN;
                        end else if (cnt_r[i] == CNT_LAST) begin
                            state_r[i]      <= ST_IDLE;
                            beam_state_r[i] <= 1'b0;
                        end else begin
                            cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_r[i]      <= ST_IDLE;
                        cnt_r[i]        <= {CNT_W{1'b0}};
                        beam_state_r[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Next total/counts: clear first, then add this cycle's hits, one bit
    // wider than the register so overflow shows up as a clamp.
    always_comb begin
        add_s = (hit_s[0] ? DEN1  : TOT_ZERO) + (hit_s[1] ? DEN5  : TOT_ZERO)
              + (hit_s[2] ? DEN10 : TOT_ZERO) + (hit_s[3] ? DEN25 : TOT_ZERO);
        if (clear_total) begin
            sum_s = add_s;
        end else begin
            sum_s = {1'b0, total_r} + add_s;
        end
        if (sum_s > TOTAL_MAX) begin
            total_next_s = {TOTAL_W{1'b1}};
            tot_clamp_s  = 1'b1;
        end else begin
            total_next_s = sum_s[TOTAL_W-1:0];
            tot_clamp_s  = 1'b0;
        end
        cnt_clamp_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (clear_total) begin
                csum_s[i] = {{COUNT_W{1'b0}}, hit_s[i]};
            end else begin
                csum_s[i] = {1'b0, count_r[i]} + {{COUNT_W{1'b0}}, hit_s[i]};
            end
            if (csum_s[i][COUNT_W]) begin
                count_next_s[i] = {COUNT_W{1'b1}};
                cnt_clamp_s[i]  = 1'b1;
            end else begin
                count_next_s[i] = csum_s[i][COUNT_W-1:0];
                cnt_clamp_s[i]  = 1'b0;
            end
        end
        sat_next_s = (clear_total ? 1'b0 : sat_r) | tot_clamp_s | (|cnt_clamp_s);
    end

    // Accumulator and last-coin latch registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            total_r   <= {TOTAL_W{1'b0}};
            for (int i = 0; i < 4; i++) begin
                count_r[i] <= {COUNT_W{1'b0}};
            end
            sat_r     <= 1'b0;
            valid_r   <= 1'b0;
            last_r    <= 4'b0000;
            overrun_r <= 1'b0;
        end else begin
            total_r <= total_next_s;
            for (int i = 0; i < 4; i++) begin
                count_r[i] <= count_next_s[i];
            end
            sat_r <= sat_next_s;
            // A new hit beats a same-cycle ack; a hit on a pending event overruns.
            if (|hit_s) begin
                valid_r <= 1'b1;
                last_r  <= hit_s;
                if (valid_r && !coin_ack) begin
                    overrun_r <= 1'b1;
                end
            end else if (coin_ack) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign total_cents = total_r;
    assign count1      = count_r[0];
    assign count5      = count_r[1];
    assign count10     = count_r[2];
    assign count25     = count_r[3];
    assign coin_valid  = valid_r;
    assign last_coin   = last_r;
    assign overrun     = overrun_r;
    assign saturated   = sat_r;
    assign beam_state  = beam_state_r;

endmodule

// File: tb/tb_coin_tally.sv
// -----------------------------------------------------------------------------
// tb_coin_tally
//   Directed scenarios plus randomized beam chatter against a behavioural
//   model: a channel accepts a new level after DEBOUNCE+1 consecutive
//   synchronised samples that differ from the accepted level.
// -----------------------------------------------------------------------------
module tb_coin_tally;

    localparam int D    = 8;
    localparam int TMAX = 65535;
    localparam int CMAX = 255;
    localparam int DEN [4] = '{1, 5, 10, 25};

    logic        clock;
    logic        reset;
    logic [3:0]  beam_n;
    logic        clear_total;
    logic        coin_ack;
    logic [15:0] total_cents;
    logic [7:0]  count1, count5, count10, count25;
    logic        coin_valid;
    logic [3:0]  last_coin;
    logic        overrun;
    logic        saturated;
    logic [3:0]  beam_state;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int       m_total;
    int       m_cnt [4];
    int       m_run [4];
    bit       m_valid, m_overrun, m_sat;
    bit [3:0] m_last, m_acc, m_d1, m_d2;

    coin_tally #(.DEBOUNCE_CYCLES(D), .TOTAL_W(16), .COUNT_W(8)) dut (
        .clock(clock), .reset(reset), .beam_n(beam_n),
        .clear_total(clear_total), .coin_ack(coin_ack),
        .total_cents(total_cents), .count1(count1), .count5(count5),
        .count10(count10), .count25(count25), .coin_valid(coin_valid),
        .last_coin(last_coin), .overrun(overrun), .saturated(saturated),
        .beam_state(beam_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] raw, input logic clr, input logic ack);
        bit [3:0] s;
        bit [3:0] hits;
        int add;
        if (r) begin
            m_total = 0; m_valid = 0; m_overrun = 0; m_sat = 0; m_last = 4'b0000;
            m_acc = 4'b1111; m_d1 = 4'b1111; m_d2 = 4'b1111;
            for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_run[i] = 0; end
        end else begin
            s = m_d2;
            hits = 4'b0000;
            for (int i = 0; i < 4; i++) begin
                if (s[i] != m_acc[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_acc[i] = s[i];
                        m_run[i] = 0;
                        hits[i]  = ~s[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = raw;
            if (clr) begin
                m_total = 0; m_sat = 0;
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            end
            add = 0;
            for (int i = 0; i < 4; i++) if (hits[i]) add += DEN[i];
            if (m_total + add > TMAX) begin m_total = TMAX; m_sat = 1; end
            else m_total = m_total + add;
            for (int i = 0; i < 4; i++) begin
                if (hits[i]) begin
                    if (m_cnt[i] + 1 > CMAX) m_sat = 1;
                    else m_cnt[i]++;
                end
            end
            if (hits != 4'b0000) begin
                if (m_valid && !ack) m_overrun = 1;
                m_valid = 1;
                m_last  = hits;
            end else if (ack) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [47:0] exp_cnt;
        logic [10:0] exp_lat;
        exp_cnt = {m_total[15:0], m_cnt[0][7:0], m_cnt[1][7:0], m_cnt[2][7:0], m_cnt[3][7:0]};
        exp_lat = {m_valid, m_last, m_overrun, m_sat, ~m_acc};
        check_val("tally", {total_cents, count1, count5, count10, count25}, exp_cnt);
        check_val("latch", {coin_valid, last_coin, overrun, saturated, beam_state}, exp_lat);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step(reset, beam_n, clear_total, coin_ack);
        #1;
        compare_all();
        clear_total = 1'b0;
        coin_ack    = 1'b0;
    endtask

    task automatic coin(input logic [3:0] mask, input int low, input int high);
        beam_n = ~mask;
        repeat (low) tick();
        beam_n = 4'b1111;
        repeat (high) tick();
    endtask

    task automatic pulse_clear();
        clear_total = 1'b1;
        tick();
    endtask

    task automatic pulse_ack();
        coin_ack = 1'b1;
        tick();
    endtask

    int hold [4];

    initial begin
        reset = 1'b1; beam_n = 4'b1111; clear_total = 1'b0; coin_ack = 1'b0;
        repeat (2) tick();
        check_val("rst_total", total_cents, 16'd0);
        check_val("rst_flags", {coin_valid, last_coin, overrun, saturated, beam_state}, 11'd0);
        reset = 1'b0;
        repeat (3) tick();

        // 1: one dime, hit exactly D+2 cycles after the raw edge
        beam_n = 4'b1011;
        repeat (10) tick();
        check_val("s1_before_hit", total_cents, 16'd0);
        tick();
        check_val("s1_at_hit", total_cents, 16'd10);
        repeat (9) tick();
        check_val("s1_beam_state", beam_state, 4'b0100);
        beam_n = 4'b1111;
        repeat (12) tick();
        check_val("s1_total", total_cents, 16'd10);
        check_val("s1_count10", count10, 8'd1);
        check_val("s1_latch", {coin_valid, last_coin}, 5'b10100);

        // 2: penny glitches shorter than the debounce window
        repeat (3) coin(4'b0001, 5, 5);
        repeat (6) tick();
        check_val("s2_total", total_cents, 16'd10);
        check_val("s2_count1", count1, 8'd0);

        // 3: quarter and nickel in the same cycle
        pulse_ack();
        pulse_clear();
        coin(4'b1010, 20, 12);
        check_val("s3_total", total_cents, 16'd30);
        check_val("s3_counts", {count5, count25}, 16'h0101);
        check_val("s3_last", last_coin, 4'b1010);

        // 4: two quarters without ack -> overrun; then ack
        pulse_ack();
        pulse_clear();
        coin(4'b1000, 12, 12);
        coin(4'b1000, 12, 12);
        check_val("s4_overrun", overrun, 1'b1);
        check_val("s4_total", total_cents, 16'd50);
        pulse_ack();
        check_val("s4_ack", {coin_valid, last_coin}, 5'b01000);

        // 5: preload 65530 (1598 x 41 + 10 + 1 + 1), then a dime saturates
        pulse_clear();
        repeat (1598) coin(4'b1111, 12, 12);
        coin(4'b0100, 12, 12);
        coin(4'b0001, 12, 12);
        coin(4'b0001, 12, 12);
        check_val("s5_preload", total_cents, 16'd65530);
        coin(4'b0100, 12, 12);
        check_val("s5_total_sat", total_cents, 16'd65535);
        check_val("s5_sat_flag", saturated, 1'b1);
        pulse_clear();
        check_val("s5_cleared", {total_cents, saturated}, 17'd0);

        // 6: clear in the nickel's hit cycle, then reset mid-ARM
        coin(4'b0001, 12, 12);
        beam_n = 4'b1101;
        for (int k = 0; k < 12; k++) begin
            clear_total = (k == 10);
            tick();
        end
        beam_n = 4'b1111;
        repeat (12) tick();
        check_val("s6_total", total_cents, 16'd5);
        check_val("s6_counts", {count1, count5}, 16'h0001);
        beam_n = 4'b1011;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        beam_n = 4'b1111;
        repeat (14) tick();
        check_val("s6_no_hit", {coin_valid, count10, beam_state}, 13'd0);

        // Randomized chatter, acks, clears and occasional resets
        for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 16);
        repeat (3000) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    beam_n[i] = ~beam_n[i];
                    hold[i] = $urandom_range(1, 16);
                end else begin
                    hold[i]--;
                end
            end
            coin_ack    = ($urandom_range(0, 3) == 0);
            clear_total = ($urandom_range(0, 99) == 0);
            reset       = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
